// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives S/R of an external RS latch with timed, mutually
// exclusive pulses, then checks the latch's Q/Q_ feedback after a recovery gap.
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int RECOV_W = 2,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic target,
    input  logic clr_err,
    input  logic Q_fb,
    input  logic Qn_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic ack,
    output logic err,
    output logic state_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        RECOV = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOV_W - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             tgt, tgt_d;
    logic             known, known_d;
    logic             state_q_d;
    logic             err_d;
    logic             s_d, r_d, ack_d, busy_d;
    logic             mism;

    // State, counter and every output are registered; next values come from
    // the combinational block so the outputs line up with the state they
    // describe (e.g. ack is high in exactly the CHECK cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tgt     <= 1'b0;
            known   <= 1'b0;
            state_q <= 1'b0;
            err     <= 1'b0;
            S       <= 1'b0;
            R       <= 1'b0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            tgt     <= tgt_d;
            known   <= known_d;
            state_q <= state_q_d;
            err     <= err_d;
            S       <= s_d;
            R       <= r_d;
            ack     <= ack_d;
            busy    <= busy_d;
        end
    end

    // Next-state logic plus registered-output precompute.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        tgt_d     = tgt;
        known_d   = known;
        state_q_d = state_q;
        mism      = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    tgt_d = target;
                    // Latch already holds the requested value: no pulse needed.
                    if (known && (target == state_q)) begin
                        state_d = CHECK;
                    end else begin
                        state_d = PULSE;
                        cnt_d   = '0;
                    end
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_d = RECOV;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RECOV: begin
                if (cnt == RECOV_LAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            CHECK: begin
                // Q=Q_=1 (or 0) is caught here too since both bits are compared.
                mism      = (Q_fb != tgt) || (Qn_fb != ~tgt);
                state_q_d = tgt;
                known_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // S and R are decoded from one target bit gated by PULSE, so they can
        // never be high together.
        s_d    = (state_d == PULSE) &&  tgt_d;
        r_d    = (state_d == PULSE) && !tgt_d;
        ack_d  = (state_d == CHECK);
        busy_d = (state_d != IDLE);
        // A fresh mismatch beats a coincident clear.
        err_d  = mism | (err & ~clr_err);
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Initiator-side controller that drives the S/R inputs of an external RS latch from a simple req/target command.
- Generates timed set or reset pulses and never asserts S and R together, so the forbidden SR=11 code cannot occur.
- Lets the feedback settle, then checks the latch's Q/Q_ feedback and flags mismatches.
- Sits between control logic (buttons, FSMs) and the latch.

Parameters:
- PULSE_W, 4, number of cycles S or R is held high per command (legal range ≥1).
- RECOV_W, 2, number of cycles both S and R are held low after a pulse, before feedback is sampled (legal range ≥1).
- CNT_W, 8, width of the internal cycle counter; must hold max(PULSE_W, RECOV_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  command request, sampled only in IDLE.
- target  in  1  desired latch value (1 = set Q, 0 = reset Q); captured with req.
- clr_err  in  1  synchronous clear of err.
- Q_fb  in  1  latch Q feedback.
- Qn_fb  in  1  latch Q_ feedback.
- S  out  1  latch set drive, registered.
- R  out  1  latch reset drive, registered.
- busy  out  1  high whenever the FSM is not IDLE.
- ack  out  1  one-cycle pulse when a command completes.
- err  out  1  sticky feedback-mismatch flag.
- state_q  out  1  tracked latch value after the last completed command.

Behaviour:
- Reset (async, rst_n=0): outputs cleared immediately — S=0, R=0, busy=0, ack=0, err=0, state_q=0.
  - Internal: known=0, counter=0, FSM=IDLE.
- FSM states: IDLE, PULSE, RECOV, CHECK. All outputs are registered.
- IDLE:
  - On a clock edge k with req=1, capture tgt=target.
  - If known=1 and tgt==state_q: skip the pulse; go to CHECK, so ack occurs at cycle k+1.
  - Otherwise go to PULSE with counter=0. Starting at cycle k+1: S=tgt, R=~tgt.
- PULSE:
  - S/R are held for exactly PULSE_W cycles (k+1 .. k+PULSE_W).
  - Counter increments each cycle; at counter==PULSE_W-1, go to RECOV and clear S and R.
- RECOV:
  - S=R=0 for exactly RECOV_W cycles; then go to CHECK.
- CHECK (one cycle):
  - ack=1.
  - Sample Q_fb/Qn_fb. If Q_fb!=tgt or Qn_fb!=~tgt, set err=1.
  - Update state_q=tgt and set known=1. Return to IDLE.
- Latency, req edge to ack cycle:
  - Pulse path: PULSE_W+RECOV_W+1 cycles (7 at default parameters).
  - Skip path: 1 cycle.
- Invariant: S&R is 0 in every cycle, including reset and all transitions.
- req while busy=1 (including the CHECK/ack cycle) is ignored; no queuing.
  - A req held high continuously is re-accepted on the first IDLE edge after ack.
- target changes while busy have no effect; tgt is frozen at capture.
- err is sticky and cleared only by clr_err=1 or reset.
  - If clr_err and a new mismatch occur in the same cycle, set wins (err=1).
- Reset mid-operation: S/R drop to 0 asynchronously and known=0.
  - The first command after reset always issues a pulse, even if target equals state_q (0).
- Feedback inputs are ignored outside CHECK. Q_fb=Qn_fb=1 in CHECK counts as a mismatch.

Test Plan:
- Reset, then req=1, target=1 at edge 0 → S=1,R=0 cycles 1–4; S=R=0 cycles 5–6; ack=1, busy=1 at cycle 7 with Q_fb=1,Qn_fb=0 → err=0, state_q=1; busy=0 at cycle 8.
- After the state is 1, req with target=1 → no S/R activity; ack at cycle 1; err unchanged.
- After the state is 1, req with target=0 → R=1,S=0 cycles 1–4; ack at cycle 7; state_q=0. Assert S&R==0 every cycle throughout.
- Command target=1 with bench forcing Q_fb=0,Qn_fb=1 at CHECK → err=1 after ack and stays 1. A later good command keeps err=1. clr_err pulse → err=0. clr_err coincident with a new mismatch → err=1.
- req pulsed at cycles 2 and 7 during an active command → ignored; a single ack at cycle 7. req held high continuously → second command starts at edge 8, next ack at cycle 15.
- Assert rst_n=0 during PULSE (cycle 2) → S=R=0 immediately, busy=0, state_q=0. After release, req with target=0 → R pulse issued (4 cycles), ack at +7.
